seq_pattern_tx: RTL and testbench

Serial pattern transmitter that generates the bit stream consumed by the team's 10001 sequence detector. It accepts a pattern word and a repeat count through a start/ready handshake, then shifts the pattern out MSB-first, one bit per enabled clock. It can insert idle gap bits between repetitions. It is used as the stimulus source and link-side driver for detector-based framing.

---
 rtl/seq_pattern_tx.sv | 141 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, one bit per tick,
// with optional idle gap bits between repetitions and a done pulse on completion.
module seq_pattern_tx #(
    parameter int               WIDTH       = 5,
    parameter logic [WIDTH-1:0] DEFAULT_PAT = 5'b10001,
    parameter int               CNT_W       = 4,
    parameter int               GAP_BITS    = 0,
    parameter logic             IDLE_LEVEL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             use_default,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             tick,
    input  logic             abort,
    output logic             ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             last,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pat_q       <= DEFAULT_PAT;
            idx_q       <= IDX_W'(WIDTH - 1);
            rem_q       <= '0;
            gap_q       <= '0;
            bit_out_q   <= IDLE_LEVEL;
            bit_valid_q <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            gap_q       <= gap_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        gap_d       = gap_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        last_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d   = use_default ? DEFAULT_PAT : pattern;
                    rem_d   = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
                    idx_d   = IDX_W'(WIDTH - 1);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // abort wins over tick so a stalled or running frame stops cleanly
                if (abort) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    bit_out_d   = pat_q[idx_q];
                    bit_valid_d = 1'b1;
                    if (idx_q == '0) begin
                        if (rem_q > CNT_W'(1)) begin
                            rem_d = rem_q - CNT_W'(1);
                            idx_d = IDX_W'(WIDTH - 1);
                            if (GAP_BITS > 0) begin
                                gap_d   = '0;
                                state_d = S_GAP;
                            end
                        end else begin
                            last_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    bit_out_d   = IDLE_LEVEL;
                    bit_valid_d = 1'b1;
                    if (gap_q == GAP_W'(GAP_BITS - 1)) begin
                        gap_d   = '0;
                        state_d = S_SHIFT;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready     = (state_q == S_IDLE);
    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign last      = last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: one back-to-back instance and one with two gap bits.
module tb_seq_pattern_tx;

    typedef struct packed {
        logic is_done;
        logic b;
        logic l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, start2 = 1'b0;
    logic       use_default = 1'b1;
    logic [4:0] pattern = 5'b00000;
    logic [3:0] repeat_cnt = 4'd1;
    logic       tick = 1'b1;
    logic       abort = 1'b0;

    logic ready0, bit_out0, bit_valid0, last0, done0;
    logic ready2, bit_out2, bit_valid2, last2, done2;

    exp_t q0[$];
    exp_t q2[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_pattern_tx #(.WIDTH(5), .DEFAULT_PAT(5'b10001), .CNT_W(4), .GAP_BITS(0), .IDLE_LEVEL(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .use_default(use_default),
        .pattern(pattern), .repeat_cnt(repeat_cnt), .tick(tick), .abort(abort),
        .ready(ready0), .bit_out(bit_out0), .bit_valid(bit_valid0), .last(last0), .done(done0)
    );

    seq_pattern_tx #(.WIDTH(5), .DEFAULT_PAT(5'b10001), .CNT_W(4), .GAP_BITS(2), .IDLE_LEVEL(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .use_default(use_default),
        .pattern(pattern), .repeat_cnt(repeat_cnt), .tick(tick), .abort(abort),
        .ready(ready2), .bit_out(bit_out2), .bit_valid(bit_valid2), .last(last2), .done(done2)
    );

    task automatic cmp(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input exp_t e);
        if (id == 0) q0.push_back(e);
        else         q2.push_back(e);
    endtask

    // Reference model of one transfer: pattern MSB-first, gap bits between repetitions, then done.
    task automatic push_frame(input int id, input logic [4:0] pat, input int rc, input int gap);
        exp_t e;
        int   reps;
        reps = (rc == 0) ? 1 : rc;
        for (int r = 0; r < reps; r++) begin
            for (int i = 4; i >= 0; i--) begin
                e.is_done = 1'b0; e.b = pat[i]; e.l = (r == reps - 1) && (i == 0);
                push_exp(id, e);
            end
            if (r < reps - 1) begin
                for (int g = 0; g < gap; g++) begin
                    e.is_done = 1'b0; e.b = 1'b0; e.l = 1'b0;
                    push_exp(id, e);
                end
            end
        end
        e.is_done = 1'b1; e.b = 1'b0; e.l = 1'b0;
        push_exp(id, e);
    endtask

    task automatic push_bits(input int id, input logic [4:0] pat, input int nbits);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            e.is_done = 1'b0; e.b = pat[4 - i]; e.l = 1'b0;
            push_exp(id, e);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic b, input logic l, input logic d);
        exp_t e;
        int   sz;
        if (v) begin
            n_cmp++;
            sz = (id == 0) ? q0.size() : q2.size();
            if (sz == 0) begin
                n_err++;
                $display("FAIL dut%0d unexpected_bit: got bit=%b last=%b expected none", id, b, l);
            end else begin
                e = (id == 0) ? q0.pop_front() : q2.pop_front();
                if (e.is_done || e.b !== b || e.l !== l) begin
                    n_err++;
                    $display("FAIL dut%0d bit: got bit=%b last=%b expected done=%b bit=%b last=%b",
                             id, b, l, e.is_done, e.b, e.l);
                end
            end
        end
        if (d) begin
            n_cmp++;
            sz = (id == 0) ? q0.size() : q2.size();
            if (sz == 0) begin
                n_err++;
                $display("FAIL dut%0d unexpected_done: got done=1 expected none", id);
            end else begin
                e = (id == 0) ? q0.pop_front() : q2.pop_front();
                if (!e.is_done || v) begin
                    n_err++;
                    $display("FAIL dut%0d done: got done=1 valid=%b expected entry done=%b bit=%b",
                             id, v, e.is_done, e.b);
                end
            end
        end
        if (l && !v) begin
            n_cmp++;
            n_err++;
            $display("FAIL dut%0d last_without_valid: got last=1 valid=0 expected last=0", id);
        end
    endtask

    always @(negedge clk) begin
        mon(0, bit_valid0, bit_out0, last0, done0);
        mon(2, bit_valid2, bit_out2, last2, done2);
    end

    task automatic start_xfer(input int id, input logic ud, input logic [4:0] pat, input logic [3:0] rc);
        use_default = ud;
        pattern     = pat;
        repeat_cnt  = rc;
        if (id == 0) start0 = 1'b1;
        else         start2 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start2 = 1'b0;
        pattern    = 5'b01010;
        repeat_cnt = 4'd9;
    endtask

    task automatic wait_idle(input int id);
        int sz;
        logic rdy;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            sz  = (id == 0) ? q0.size() : q2.size();
            rdy = (id == 0) ? ready0 : ready2;
            if (sz == 0 && rdy) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL dut%0d timeout: got pending=%0d expected 0 within 300 cycles", id,
                 (id == 0) ? q0.size() : q2.size());
    endtask

    initial begin
        logic [4:0] dp;
        logic [7:0] tk;
        logic       exp_hold;
        int         n;
        dp = 5'b10001;
        tk = 8'b11011001;

        #12;
        cmp("rst_ready0", ready0, 1'b1);
        cmp("rst_valid0", bit_valid0, 1'b0);
        cmp("rst_bit0", bit_out0, 1'b0);
        cmp("rst_last0", last0, 1'b0);
        cmp("rst_done0", done0, 1'b0);
        cmp("rst_ready2", ready2, 1'b1);
        cmp("rst_valid2", bit_valid2, 1'b0);
        cmp("rst_done2", done2, 1'b0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // default pattern, single repetition
        push_frame(0, 5'b10001, 1, 0);
        start_xfer(0, 1'b1, 5'b00000, 4'd1);
        wait_idle(0);
        cmp("ready_after_done", ready0, 1'b1);

        // user pattern, three back-to-back repetitions
        push_frame(0, 5'b11010, 3, 0);
        start_xfer(0, 1'b0, 5'b11010, 4'd3);
        wait_idle(0);

        // two gap bits between repetitions: 10001 00 10001
        push_frame(2, 5'b10001, 2, 2);
        start_xfer(2, 1'b1, 5'b00000, 4'd2);
        wait_idle(2);

        // repeat_cnt of zero sends once
        push_frame(0, 5'b01101, 0, 0);
        start_xfer(0, 1'b0, 5'b01101, 4'd0);
        wait_idle(0);

        // tick stalls: bit_out holds the last emitted bit
        push_frame(0, dp, 1, 0);
        start_xfer(0, 1'b1, 5'b00000, 4'd1);
        n = 0;
        for (int i = 7; i >= 0; i--) begin
            tick = tk[i];
            @(posedge clk); #1;
            if (tk[i]) begin
                n++;
            end else begin
                exp_hold = dp[5 - n];
                cmp("stall_hold", bit_out0, exp_hold);
                cmp("stall_valid", bit_valid0, 1'b0);
            end
        end
        tick = 1'b1;
        wait_idle(0);

        // abort after the third bit, with a start pulse while busy
        push_bits(0, dp, 3);
        start_xfer(0, 1'b1, 5'b00000, 4'd1);
        @(posedge clk); #1;
        use_default = 1'b0; pattern = 5'b01110; repeat_cnt = 4'd3; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        cmp("abort_ready", ready0, 1'b1);
        cmp("abort_valid", bit_valid0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (q0.size() != 0) begin
            n_err++;
            $display("FAIL abort_pending: got %0d expected 0", q0.size());
        end

        // asynchronous reset in the middle of a transfer
        push_bits(0, 5'b11010, 4);
        start_xfer(0, 1'b0, 5'b11010, 4'd2);
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        cmp("midrst_ready", ready0, 1'b1);
        cmp("midrst_valid", bit_valid0, 1'b0);
        cmp("midrst_bit", bit_out0, 1'b0);
        cmp("midrst_last", last0, 1'b0);
        cmp("midrst_done", done0, 1'b0);
        n_cmp++;
        if (q0.size() != 0) begin
            n_err++;
            $display("FAIL midrst_pending: got %0d expected 0", q0.size());
        end
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        cmp("post_rst_ready", ready0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200us");
        $fatal(1, "watchdog");
    end

endmodule
